// File: rtl/qam_pkg.sv
// Shared constants and index helpers for the QAM slicer stream.
package qam_pkg;

    localparam int unsigned DIN_W_DEF = 16;
    localparam int unsigned K_DEF     = 3;
    // Widest per-axis index the helpers below accept.
    localparam int unsigned MAX_K     = 16;

    // Binary-reflected Gray encode; zero-extended inputs give zero-extended results.
    function automatic logic [MAX_K-1:0] gray_enc(input logic [MAX_K-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Two's complement field -> offset binary by flipping the field MSB (bit k-1).
    function automatic logic [MAX_K-1:0] offset_bin(input logic [MAX_K-1:0] idx,
                                                    input int unsigned     k);
        return idx ^ (MAX_K'(1) << (k - 1));
    endfunction

endpackage

// File: rtl/qam_axis_slice.sv
// One axis: optional round, positive saturation and K-bit offset-binary index.
module qam_axis_slice
    import qam_pkg::*;
#(
    parameter int unsigned DIN_W = DIN_W_DEF,
    parameter int unsigned K     = K_DEF
) (
    input  logic [DIN_W-1:0] sample_i,
    input  logic             round_i,
    output logic [K-1:0]     idx_o,
    output logic             sat_o
);

    // Half an output LSB, added when rounding to nearest.
    localparam logic [DIN_W:0] RND_INC = (DIN_W + 1)'(1) << (DIN_W - K - 1);

    logic [DIN_W:0] sum;
    logic [K-1:0]   raw;

    // Sign-extended add; overflow can only be positive, seen as sign 0 with bit DIN_W-1 set.
    always_comb begin
        sum   = {sample_i[DIN_W-1], sample_i} + (round_i ? RND_INC : '0);
        sat_o = ~sum[DIN_W] & sum[DIN_W-1];
        raw   = sat_o ? ({K{1'b1}} >> 1) : sum[DIN_W-1 -: K];
        idx_o = K'(offset_bin(MAX_K'(raw), K));
    end

endmodule

// File: rtl/qam_slicer_stream.sv
// Streaming I/Q slicer: slice (stage 1) -> Gray map (stage 2), valid/ready with stats.
module qam_slicer_stream
    import qam_pkg::*;
#(
    parameter int unsigned DIN_W = DIN_W_DEF,
    parameter int unsigned K     = K_DEF,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DIN_W-1:0] in_i,
    input  logic [DIN_W-1:0] in_q,
    input  logic             in_round,
    input  logic             in_gray,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*K-1:0]   out_symbol,
    output logic             out_sat,
    input  logic             clr_stats,
    output logic [CNT_W-1:0] sym_count,
    output logic [CNT_W-1:0] sat_count
);

    logic           adv1, adv2;
    logic [K-1:0]   idx_i, idx_q;
    logic           sat_i, sat_q;

    logic           s1_valid_q;
    logic [K-1:0]   s1_idx_i_q, s1_idx_q_q;
    logic           s1_sat_q, s1_gray_q;

    logic           out_valid_q, out_sat_q;
    logic [2*K-1:0] out_sym_q, out_sym_d;

    logic [CNT_W-1:0] sym_cnt_q, sym_cnt_d, sat_cnt_q, sat_cnt_d;

    qam_axis_slice #(.DIN_W(DIN_W), .K(K)) u_slice_i (
        .sample_i (in_i),
        .round_i  (in_round),
        .idx_o    (idx_i),
        .sat_o    (sat_i)
    );

    qam_axis_slice #(.DIN_W(DIN_W), .K(K)) u_slice_q (
        .sample_i (in_q),
        .round_i  (in_round),
        .idx_o    (idx_q),
        .sat_o    (sat_q)
    );

    // Pipeline advance conditions; in_ready is the only comb path (from out_ready).
    always_comb begin
        adv2     = ~out_valid_q | out_ready;
        adv1     = ~s1_valid_q | adv2;
        in_ready = adv1;
    end

    // Stage 1: capture sliced indices, combined sat flag and per-beat Gray mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_idx_i_q <= '0;
            s1_idx_q_q <= '0;
            s1_sat_q   <= 1'b0;
            s1_gray_q  <= 1'b0;
        end else if (adv1) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_idx_i_q <= idx_i;
                s1_idx_q_q <= idx_q;
                s1_sat_q   <= sat_i | sat_q;
                s1_gray_q  <= in_gray;
            end
        end
    end

    // Stage 2 mapping: optional Gray encode on each axis, then pack {I, Q}.
    always_comb begin
        out_sym_d = {s1_idx_i_q, s1_idx_q_q};
        if (s1_gray_q) begin
            out_sym_d = {K'(gray_enc(MAX_K'(s1_idx_i_q))), K'(gray_enc(MAX_K'(s1_idx_q_q)))};
        end
    end

    // Stage 2 register; holds symbol and sat stable while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_sym_q   <= '0;
            out_sat_q   <= 1'b0;
        end else if (adv2) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_sym_q <= out_sym_d;
                out_sat_q <= s1_sat_q;
            end
        end
    end

    // Statistics next state: clear wins over a same-cycle increment.
    always_comb begin
        sym_cnt_d = sym_cnt_q;
        sat_cnt_d = sat_cnt_q;
        if (clr_stats) begin
            sym_cnt_d = '0;
            sat_cnt_d = '0;
        end else if (out_valid_q && out_ready) begin
            sym_cnt_d = sym_cnt_q + CNT_W'(1);
            if (out_sat_q) begin
                sat_cnt_d = sat_cnt_q + CNT_W'(1);
            end
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sym_cnt_q <= '0;
            sat_cnt_q <= '0;
        end else begin
            sym_cnt_q <= sym_cnt_d;
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_symbol = out_sym_q;
    assign out_sat    = out_sat_q;
    assign sym_count  = sym_cnt_q;
    assign sat_count  = sat_cnt_q;

endmodule

// File: doc/qam_slicer_stream.md
Name: qam_slicer_stream

Overview:
- Streaming, parametrised successor to the combinational I/Q-to-symbol mapper.
- Takes signed I/Q sample pairs on a valid/ready input and slices each axis to K bits. Truncation or round-to-nearest is selectable, with saturation.
- Optional Gray coding per axis. Emits {I_idx, Q_idx} symbols through a 2-stage stallable pipeline.
- Keeps symbol and saturation statistics. Sits between the sample source (file reader or front-end) and the symbol checker.

Parameters:
- DIN_W, 16, signed sample width per axis.
- K, 3, output index bits per axis (1 <= K < DIN_W); symbol width is 2*K.
- CNT_W, 32, width of the statistics counters.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input sample pair valid.
- in_ready  out  1  block accepts the pair this cycle.
- in_i  in  DIN_W  in-phase sample, two's complement.
- in_q  in  DIN_W  quadrature sample, two's complement.
- in_round  in  1  0 = truncate, 1 = round-to-nearest; travels with the beat.
- in_gray  in  1  0 = binary index, 1 = Gray index; travels with the beat.
- out_valid  out  1  symbol valid.
- out_ready  in  1  downstream accepts the symbol.
- out_symbol  out  2*K  {I_idx, Q_idx}.
- out_sat  out  1  this symbol saturated on I or Q.
- clr_stats  in  1  synchronous clear of both counters.
- sym_count  out  CNT_W  output handshakes since reset/clear.
- sat_count  out  CNT_W  output handshakes with out_sat=1.

Behaviour:
- Reset (async, asserted): out_valid=0, out_symbol=0, out_sat=0, sym_count=0, sat_count=0, and internal stage-1 valid=0. in_ready is 1 from the first cycle after release.
- Per-axis slice (stage 1, registered):
  - Truncate: v = sample.
  - Round: v = sample + 2^(DIN_W-K-1), computed at DIN_W+1 bits.
  - If the result exceeds 2^(DIN_W-1)-1, v = 2^(DIN_W-1)-1 and the sat flag is set. Round can only overflow positive; truncate never sets sat.
  - idx = v[DIN_W-1 -: K] with its MSB inverted (offset binary: most negative -> 0, zero -> 2^(K-1)).
- Map (stage 2, registered):
  - If the beat's gray flag is set, idx_g = idx ^ (idx >> 1); otherwise the index is unchanged.
  - out_symbol = {I_idx, Q_idx}; out_sat = sat_I | sat_Q.
- Handshake and pipeline:
  - adv2 = !out_valid | out_ready.
  - adv1 = !s1_valid | adv2.
  - in_ready = adv1. It may depend combinationally on out_ready; no other comb path from input to output.
  - A beat transfers when valid & ready.
  - Latency with out_ready=1 is 2 cycles from input handshake to out_valid. Throughput is 1 symbol/cycle.
  - While out_valid=1 and out_ready=0, out_symbol/out_sat are held stable. At most 2 beats are buffered; in_ready=0 when both stages are full and out_ready=0.
  - Order is preserved; no beat is dropped or duplicated.
  - in_round/in_gray are captured per beat, so a mode change mid-stream affects only later beats.
- Counters:
  - sym_count increments on out_valid & out_ready; sat_count increments additionally when out_sat=1.
  - Both wrap modulo 2^CNT_W.
  - clr_stats has priority over a same-cycle increment; the result is 0.
- Reset mid-operation: in-flight beats are discarded and nothing is emitted after release until new input arrives.

Decomposition:
- Package qam_pkg holds:
  - a function for the Gray encode;
  - a function for the offset-binary conversion;
  - default parameter constants (DIN_W=16, K=3).
- One sub-module, qam_axis_slice (DIN_W, K): combinational round/saturate/index for one axis. It is instantiated twice, for I and Q, feeding the stage-1 registers.

Test Plan:
- Truncate/binary, K=3, out_ready=1, pairs (I,Q) = (0x8000,0x7FFF) and (0x0000,0x1FFF) -> symbols 0x07 and 0x24, each 2 cycles after its handshake, out_sat=0.
- Round, (0x1FFF,0x0000) -> I_idx 5, Q_idx 4, symbol 0x2C. Same beat with in_gray=1 -> 0x3E.
- Saturation: round, (0x7FFF,0x7800) -> symbol 0x3F, out_sat=1, sat_count increments 0 -> 1, sym_count 0 -> 1.
- Backpressure: 6 consecutive beats, out_ready low for cycles 3-5 -> in_ready falls once 2 beats are buffered. out_symbol stays stable while stalled. All 6 symbols arrive in order; sym_count=6.
- Async rst asserted with 2 beats in flight -> out_valid=0 immediately and counters 0. No stale symbol is emitted after release.
- clr_stats asserted in the same cycle as an output handshake -> sym_count=0 and sat_count=0 the next cycle.
